// File: rtl/serializador_de_sequencia_pkg.sv
// rtl/serializador_de_sequencia_pkg.sv - shared types and constants for the serializer
package serializador_de_sequencia_pkg;

  // Serializer FSM states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  // Default word width, matching the sequence width of the downstream detector
  localparam int SEQ_WIDTH = 4;

endpackage

// File: rtl/serializador_de_sequencia_if.sv
// rtl/serializador_de_sequencia_if.sv - word input handshake and serial output bundle
interface serializador_de_sequencia_if
  import serializador_de_sequencia_pkg::*;
#(
  parameter int WIDTH = SEQ_WIDTH
);

  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             din_ready;
  logic             out;
  logic             out_valid;
  logic             last;
  logic             busy;

  // Producer / observer side
  modport master (
    output din, din_valid,
    input  din_ready, out, out_valid, last, busy
  );

  // Serializer side
  modport slave (
    input  din, din_valid,
    output din_ready, out, out_valid, last, busy
  );

endinterface

// File: rtl/serializador_de_sequencia_contador_gap.sv
// rtl/serializador_de_sequencia_contador_gap.sv - loadable saturating down-counter with zero/one flags
module contador_gap #(
  parameter int CW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  input  logic          dec,
  output logic          zero,
  output logic          one
);

  logic [CW-1:0] count;

  // Load has priority; decrement stops at zero so the counter never wraps
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - CW'(1);
    end
  end

  assign zero = (count == '0);
  assign one  = (count == CW'(1));

endmodule

// File: rtl/serializador_de_sequencia.sv
// rtl/serializador_de_sequencia.sv - parallel-to-serial stage feeding the sequence detector
module serializador_de_sequencia
  import serializador_de_sequencia_pkg::*;
#(
  parameter int WIDTH     = SEQ_WIDTH,
  parameter int GAP       = 0,
  parameter int MSB_FIRST = 1
) (
  input logic                        clk,
  input logic                        rst,
  serializador_de_sequencia_if.slave bus
);

  localparam int BW = $clog2(WIDTH);

  state_t           state, state_n;
  logic [WIDTH-1:0] shreg, shreg_n;
  logic             out_q, out_n;
  logic             valid_q, valid_n;
  logic             last_q, last_n;
  logic             accept;
  logic             bit_zero, bit_one, bit_dec;
  logic             gap_one;

  // Bit that leaves the word first
  function automatic logic head(input logic [WIDTH-1:0] w);
    return (MSB_FIRST != 0) ? w[WIDTH-1] : w[0];
  endfunction

  // Word with its leading bit consumed
  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
    return (MSB_FIRST != 0) ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
  endfunction

  // Ready comes from registered state only: idle, or final bit of a word when streaming
  assign bus.din_ready = (state == ST_IDLE) ||
                         ((state == ST_SHIFT) && bit_zero && (GAP == 0));
  assign accept        = bus.din_valid && bus.din_ready;

  // Next state and next registered outputs; an accept overrides the end-of-word path
  always_comb begin
    state_n = state;
    shreg_n = shreg;
    out_n   = 1'b0;
    valid_n = 1'b0;
    last_n  = 1'b0;
    bit_dec = 1'b0;
    case (state)
      ST_IDLE: begin
      end
      ST_SHIFT: begin
        if (!bit_zero) begin
          out_n   = head(shreg);
          shreg_n = advance(shreg);
          valid_n = 1'b1;
          last_n  = bit_one;
          bit_dec = 1'b1;
        end else if (GAP > 0) begin
          state_n = ST_GAP;
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_GAP: begin
        if (gap_one) begin
          state_n = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
    if (accept) begin
      state_n = ST_SHIFT;
      out_n   = head(bus.din);
      shreg_n = advance(bus.din);
      valid_n = 1'b1;
      last_n  = 1'b0;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Shift register and registered serial outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      shreg   <= '0;
      out_q   <= 1'b0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      shreg   <= shreg_n;
      out_q   <= out_n;
      valid_q <= valid_n;
      last_q  <= last_n;
    end
  end

  // Bits still held in the shift register after the one on out
  contador_gap #(.CW(BW)) u_bit_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (accept),
    .load_val (BW'(WIDTH - 1)),
    .dec      (bit_dec),
    .zero     (bit_zero),
    .one      (bit_one)
  );

  if (GAP > 0) begin : g_gap
    localparam int GW = $clog2(GAP + 1);
    logic gap_zero, gap_load, gap_dec;
    assign gap_load = (state == ST_SHIFT) && (state_n == ST_GAP);
    assign gap_dec  = (state == ST_GAP) && !gap_zero;
    // Idle cycles left in the gap, including the current one
    contador_gap #(.CW(GW)) u_gap_cnt (
      .clk      (clk),
      .rst      (rst),
      .load     (gap_load),
      .load_val (GW'(GAP)),
      .dec      (gap_dec),
      .zero     (gap_zero),
      .one      (gap_one)
    );
  end else begin : g_nogap
    assign gap_one = 1'b1;
  end

  assign bus.out       = out_q;
  assign bus.out_valid = valid_q;
  assign bus.last      = last_q;
  assign bus.busy      = (state != ST_IDLE);

endmodule

// File: tb/tb_serializador_de_sequencia.sv
// tb/tb_serializador_de_sequencia.sv - randomized and directed checks of three serializer configurations
module tb_serializador_de_sequencia;

  localparam int NI = 3;
  localparam int W0 = 4, G0 = 0, M0 = 1;
  localparam int W1 = 4, G1 = 2, M1 = 1;
  localparam int W2 = 5, G2 = 1, M2 = 0;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int pw[NI], pg[NI], pm[NI];

  logic [7:0] din_a[NI];
  logic       dv_a[NI];
  logic       rdy_a[NI], out_a[NI], val_a[NI], last_a[NI], busy_a[NI];

  serializador_de_sequencia_if #(.WIDTH(W0)) if0 ();
  serializador_de_sequencia_if #(.WIDTH(W1)) if1 ();
  serializador_de_sequencia_if #(.WIDTH(W2)) if2 ();

  serializador_de_sequencia #(.WIDTH(W0), .GAP(G0), .MSB_FIRST(M0)) dut0 (.clk(clk), .rst(rst), .bus(if0));
  serializador_de_sequencia #(.WIDTH(W1), .GAP(G1), .MSB_FIRST(M1)) dut1 (.clk(clk), .rst(rst), .bus(if1));
  serializador_de_sequencia #(.WIDTH(W2), .GAP(G2), .MSB_FIRST(M2)) dut2 (.clk(clk), .rst(rst), .bus(if2));

  assign if0.din = din_a[0][W0-1:0];
  assign if1.din = din_a[1][W1-1:0];
  assign if2.din = din_a[2][W2-1:0];
  assign if0.din_valid = dv_a[0];
  assign if1.din_valid = dv_a[1];
  assign if2.din_valid = dv_a[2];
  assign rdy_a[0] = if0.din_ready;  assign out_a[0] = if0.out;  assign val_a[0] = if0.out_valid;
  assign rdy_a[1] = if1.din_ready;  assign out_a[1] = if1.out;  assign val_a[1] = if1.out_valid;
  assign rdy_a[2] = if2.din_ready;  assign out_a[2] = if2.out;  assign val_a[2] = if2.out_valid;
  assign last_a[0] = if0.last;  assign busy_a[0] = if0.busy;
  assign last_a[1] = if1.last;  assign busy_a[1] = if1.busy;
  assign last_a[2] = if2.last;  assign busy_a[2] = if2.busy;

  // Model: cycles elapsed since the accepting edge (0 = idle); 1..W data, W+1..W+G gap
  int         pos[NI];
  logic [7:0] word[NI];

  // Directed producer word lists
  logic [7:0] plan[NI][0:3];
  int         plan_n[NI], plan_k[NI];

  // Observed serial streams
  logic [63:0] stream[NI];
  int          slen[NI], first_v[NI], last_v[NI];
  logic [3:0]  win0;
  int          det_cnt, det_at;

  int n_cmp, n_err, cyc;

  task automatic chk(input string nm, input int inst, input logic act, input logic want);
    n_cmp++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s[%0d] cycle %0d: got %b expected %b", nm, inst, cyc, act, want);
    end
  endtask

  task automatic chkv(input string nm, input logic [63:0] act, input logic [63:0] want);
    n_cmp++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, want);
    end
  endtask

  task automatic expect_now(input int i, output logic eo, output logic ev, output logic el,
                            output logic eb, output logic er);
    int p;
    p  = pos[i];
    ev = (p >= 1) && (p <= pw[i]);
    eo = 1'b0;
    if (ev) eo = (pm[i] != 0) ? word[i][pw[i] - p] : word[i][p - 1];
    el = (p == pw[i]);
    eb = (p != 0);
    er = (p == 0) || ((p == pw[i]) && (pg[i] == 0));
  endtask

  task automatic compare_all();
    logic eo, ev, el, eb, er;
    cyc++;
    for (int i = 0; i < NI; i++) begin
      expect_now(i, eo, ev, el, eb, er);
      chk("out", i, out_a[i], eo);
      chk("out_valid", i, val_a[i], ev);
      chk("last", i, last_a[i], el);
      chk("busy", i, busy_a[i], eb);
      chk("din_ready", i, rdy_a[i], er);
      if (val_a[i]) begin
        stream[i] = {stream[i][62:0], out_a[i]};
        slen[i]++;
        if (first_v[i] < 0) first_v[i] = cyc;
        last_v[i] = cyc;
      end
    end
    if (val_a[0]) begin
      win0 = {win0[2:0], out_a[0]};
      if ((slen[0] >= 4) && (win0 == 4'b0110)) begin
        det_cnt++;
        det_at = slen[0];
      end
    end
  endtask

  task automatic clear_streams();
    for (int i = 0; i < NI; i++) begin
      stream[i] = '0; slen[i] = 0; first_v[i] = -1; last_v[i] = -1;
    end
    win0 = '0; det_cnt = 0; det_at = 0;
  endtask

  task automatic set_plan(input logic [7:0] a, input logic [7:0] b, input int n);
    for (int i = 0; i < NI; i++) begin
      plan[i][0] = a; plan[i][1] = b; plan_n[i] = n; plan_k[i] = 0;
    end
  endtask

  // Drive inputs for the next edge, advance the model across it, then compare
  task automatic step(input logic r, input logic rnd);
    logic eo, ev, el, eb, er;
    rst = r;
    for (int i = 0; i < NI; i++) begin
      if (rnd) begin
        dv_a[i]  = ($urandom_range(0, 3) != 0);
        din_a[i] = 8'($urandom);
      end else begin
        dv_a[i]  = (plan_k[i] < plan_n[i]);
        din_a[i] = dv_a[i] ? plan[i][plan_k[i]] : 8'h00;
      end
      expect_now(i, eo, ev, el, eb, er);
      if (r) begin
        pos[i] = 0;
      end else if (dv_a[i] && er) begin
        word[i] = din_a[i];
        pos[i]  = 1;
        if (!rnd) plan_k[i]++;
      end else if (pos[i] != 0) begin
        pos[i] = (pos[i] == pw[i] + pg[i]) ? 0 : pos[i] + 1;
      end
    end
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    pw = '{W0, W1, W2};
    pg = '{G0, G1, G2};
    pm = '{M0, M1, M2};
    n_cmp = 0; n_err = 0; cyc = 0;
    rst = 1'b1;
    for (int i = 0; i < NI; i++) begin
      pos[i] = 0; word[i] = '0; din_a[i] = '0; dv_a[i] = 1'b0;
    end
    set_plan(8'h00, 8'h00, 0);
    clear_streams();

    step(1'b1, 1'b0);
    step(1'b1, 1'b0);

    // Single word
    clear_streams();
    set_plan(8'b0110, 8'h00, 1);
    for (int k = 0; k < 12; k++) step(1'b0, 1'b0);
    chkv("t1_stream0", stream[0], 64'b0110);
    chkv("t1_len0", 64'(slen[0]), 64'd4);
    chkv("t1_stream1", stream[1], 64'b0110);
    chkv("t1_stream2", stream[2], 64'b01100);

    // Two words back to back (gap depends on instance)
    clear_streams();
    set_plan(8'b0110, 8'b1001, 2);
    plan[1][0] = 8'b1100; plan[1][1] = 8'b0011;
    for (int k = 0; k < 24; k++) step(1'b0, 1'b0);
    chkv("t2_stream0", stream[0], 64'b01101001);
    chkv("t2_span0", 64'(last_v[0] - first_v[0] + 1), 64'd8);
    chkv("t3_stream1", stream[1], 64'b11000011);
    chkv("t3_span1", 64'(last_v[1] - first_v[1] + 1), 64'd11);
    chkv("t3_stream2", stream[2], 64'b0110010010);
    chkv("t3_span2", 64'(last_v[2] - first_v[2] + 1), 64'd12);

    // Bit order
    clear_streams();
    set_plan(8'b0001, 8'h00, 1);
    for (int k = 0; k < 10; k++) step(1'b0, 1'b0);
    chkv("t4_stream0", stream[0], 64'b0001);
    chkv("t4_stream2", stream[2], 64'b10000);

    // Reset mid-word, then reset together with an accept
    set_plan(8'b1010, 8'b0110, 2);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    chk("t5_valid_after_rst", 0, val_a[0], 1'b0);
    chk("t5_busy_after_rst", 0, busy_a[0], 1'b0);
    chk("t5_ready_after_rst", 0, rdy_a[0], 1'b1);
    clear_streams();
    step(1'b1, 1'b0);
    chk("t5_rst_accept_dropped", 0, busy_a[0], 1'b0);
    for (int k = 0; k < 10; k++) step(1'b0, 1'b0);
    chkv("t5_stream0", stream[0], 64'b0110);
    chkv("t5_len0", 64'(slen[0]), 64'd4);
    chkv("t5_stream2", stream[2], 64'b01100);

    // Stream as seen by a 0110 detector
    clear_streams();
    set_plan(8'b0110, 8'b1111, 2);
    for (int k = 0; k < 14; k++) step(1'b0, 1'b0);
    chkv("t6_stream0", stream[0], 64'b01101111);
    chkv("t6_det_count", 64'(det_cnt), 64'd1);
    chkv("t6_det_at_bit", 64'(det_at), 64'd4);

    // Randomized traffic with occasional resets
    for (int k = 0; k < 800; k++) step(($urandom_range(0, 63) == 0), 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
